keccak_perm_seq: RTL and testbench
==================================

# keccak_perm_seq

Parametrised multi-block permutation sequencer driving the Keccak round datapath. It accepts a job of N blocks, then for each block it:
- launches the datapath,
- steps a round index through NUM_ROUNDS rounds,
- requests the next block between permutations.

On completion it raises a sticky status and a one-cycle interrupt. It sits between the bus-side register/absorb logic and the Keccak-f datapath, and replaces the fixed 24-round single-shot controller.

## Interface
- NUM_ROUNDS, 24, rounds per permutation (>= 2; 24 = Keccak-f[1600], 12 = TurboSHAKE/KangarooTwelve)
- BLK_CNT_W, 8, width of block count/index
- ROUND_W (localparam), max($clog2(NUM_ROUNDS),1)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  job start request, sampled in IDLE only
- num_blocks_i  in  BLK_CNT_W  permutations in job, latched on start acceptance
- ready_dp_i  in  1  datapath idle and loaded
- blk_valid_i  in  1  next block has been XORed into state
- abort_i  in  1  job abort (active only with KECCAK_PERM_SEQ_ABORT_EN)
- start_dp_o  out  1  one-cycle datapath launch pulse
- round_en_o  out  1  datapath executes one round this cycle
- round_idx_o  out  ROUND_W  current round index (round-constant select)
- blk_req_o  out  1  requesting next block
- blk_idx_o  out  BLK_CNT_W  index of block being permuted/requested
- busy_o  out  1  job in progress
- status_o  out  1  sticky job-done flag
- keccak_intr  out  1  one-cycle completion interrupt

## Operation
- States: IDLE, LAUNCH, ROUND, BLK_WAIT, DONE. All outputs are Moore decodes of the state and counter registers.
- IDLE:
  - busy_o=0.
  - start_i && ready_dp_i && num_blocks_i!=0: latch num_blocks_i, set blk_idx=0, clear status_o, go to LAUNCH.
  - start_i && ready_dp_i && num_blocks_i==0: clear status_o, go to DONE.
  - start_i without ready_dp_i: ignored; stay in IDLE.
- LAUNCH: start_dp_o=1, round_idx=0, busy_o=1; go to ROUND.
- ROUND:
  - round_en_o=1; round_idx_o increments each cycle 0..NUM_ROUNDS-1.
  - At round_idx==NUM_ROUNDS-1, if blk_idx==latched count-1: go to DONE.
  - Otherwise: blk_idx+1, go to BLK_WAIT.
- BLK_WAIT:
  - blk_req_o=1, busy_o=1.
  - blk_valid_i && ready_dp_i: go to LAUNCH.
  - Otherwise hold indefinitely.
- DONE: keccak_intr=1 and status_o set (registered, sticky) for exactly one cycle; go to IDLE.
- status_o stays 1 until the next accepted start, an abort, or reset.
- start_i outside IDLE (including the DONE cycle) is ignored; it is not queued.
- round_idx never exceeds NUM_ROUNDS-1. blk_idx never reaches the latched count. No wrap-around.
- Reset (any time, including mid-job): state IDLE, counters 0, every output 0 immediately (asynchronous).

## Timing
- Start accepted at edge k. LAUNCH occupies cycle k+1 and ROUND occupies cycles k+2..k+1+NUM_ROUNDS.
- Single block: DONE is at cycle k+2+NUM_ROUNDS. With NUM_ROUNDS=24, keccak_intr is high 26 cycles after the start edge.
- Per extra block: 1 (BLK_WAIT, minimum) + 1 (LAUNCH) + NUM_ROUNDS cycles.
- Job latency: 1 + B·(NUM_ROUNDS+1) + (B-1)·W_blk + 1 cycles, where B = block count and W_blk = BLK_WAIT cycles per gap (>= 1).
- Earliest next start sampled: the cycle after DONE (back-to-back jobs have a 1-cycle IDLE gap).
- start_dp_o and round_en_o are never high together. blk_req_o is never high with round_en_o.

## Configuration
- KECCAK_PERM_SEQ_ABORT_EN defined:
  - abort_i high in LAUNCH, ROUND, BLK_WAIT or DONE moves to IDLE at the next edge.
  - Counters are cleared and status_o is cleared; keccak_intr is not asserted for that job.
  - Abort has priority over every other transition, including DONE entry on the same edge.
  - abort_i in IDLE has no effect.
- Undefined: the abort_i port is still present but ignored; it generates no logic.

## Test plan
- NUM_ROUNDS=24, num_blocks_i=1, start_i pulse with ready_dp_i=1 -> start_dp_o at +1; round_idx_o 0..23 on cycles +2..+25; keccak_intr one cycle at +26; status_o stays 1 afterwards.
- num_blocks_i=3, blk_valid_i delayed 5 cycles each gap -> blk_req_o with blk_idx_o=1 then 2; three start_dp_o pulses; exactly 72 round_en_o cycles; one interrupt.
- NUM_ROUNDS=12 build, num_blocks_i=0 -> no start_dp_o and no round_en_o; keccak_intr at +1; status_o=1.
- start_i held high through a 2-block job with ready_dp_i=0 at the first attempt -> no acceptance until ready_dp_i=1; no second job starts before IDLE; status_o clears on the new acceptance.
- rst_ni low at round_idx_o=10 -> all outputs 0 asynchronously. After release, a new 1-block job completes in 26 cycles.
- With KECCAK_PERM_SEQ_ABORT_EN, abort_i at round_idx_o=5 -> IDLE next cycle, status_o=0, no keccak_intr. Without the macro, the same stimulus completes normally.

Source files
------------

// File: rtl/keccak_perm_seq_if.sv
// ---------------------------------------------------------------------------
// keccak_perm_seq_if
// Handshake bundle between the bus-side absorb logic, the permutation
// sequencer and the Keccak-f round datapath.
//   slave  modport : sequencer side (takes job/datapath status, drives control)
//   master modport : job issuer / datapath side
// Signals:
//   start_i, num_blocks_i        job request and block count
//   ready_dp_i, blk_valid_i      datapath idle/loaded, next block absorbed
//   abort_i                      job abort (honoured only with
//                                KECCAK_PERM_SEQ_ABORT_EN)
//   start_dp_o, round_en_o       datapath launch pulse, round enable
//   round_idx_o, blk_idx_o       round-constant select, current block index
//   blk_req_o, busy_o            next-block request, job in progress
//   status_o, keccak_intr        sticky done flag, one-cycle interrupt
// ---------------------------------------------------------------------------
interface keccak_perm_seq_if #(
   parameter int NUM_ROUNDS = 24,
   parameter int BLK_CNT_W  = 8
);
   localparam int ROUND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

   logic                 start_i;
   logic [BLK_CNT_W-1:0] num_blocks_i;
   logic                 ready_dp_i;
   logic                 blk_valid_i;
   logic                 abort_i;
   logic                 start_dp_o;
   logic                 round_en_o;
   logic [ROUND_W-1:0]   round_idx_o;
   logic                 blk_req_o;
   logic [BLK_CNT_W-1:0] blk_idx_o;
   logic                 busy_o;
   logic                 status_o;
   logic                 keccak_intr;

   modport slave (
      input  start_i, num_blocks_i, ready_dp_i, blk_valid_i, abort_i,
      output start_dp_o, round_en_o, round_idx_o, blk_req_o, blk_idx_o,
             busy_o, status_o, keccak_intr
   );

   modport master (
      output start_i, num_blocks_i, ready_dp_i, blk_valid_i, abort_i,
      input  start_dp_o, round_en_o, round_idx_o, blk_req_o, blk_idx_o,
             busy_o, status_o, keccak_intr
   );
endinterface

// File: rtl/keccak_perm_seq.sv
// ---------------------------------------------------------------------------
// keccak_perm_seq
// Multi-block permutation sequencer for the Keccak-f round datapath.
// Accepts a job of N blocks; for each block it launches the datapath, steps
// the round index through NUM_ROUNDS rounds and, between permutations,
// requests the next block. Completion raises a sticky status flag and a
// one-cycle interrupt.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     keccak_perm_seq_if.slave (job, datapath handshake, status)
// Optional feature:
//   KECCAK_PERM_SEQ_ABORT_EN  when defined, abort_i returns any active job
//                             to IDLE without an interrupt; otherwise
//                             abort_i is ignored.
// All outputs come straight from registers updated with the state.
// ---------------------------------------------------------------------------
module keccak_perm_seq #(
   parameter int NUM_ROUNDS = 24,
   parameter int BLK_CNT_W  = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   keccak_perm_seq_if.slave       bus
);
   localparam int ROUND_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_ROUND,
      S_BLK_WAIT,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [BLK_CNT_W-1:0] r_blk_cnt;
   logic [BLK_CNT_W-1:0] r_blk_idx;
   logic [ROUND_W-1:0]   r_round_idx;
   logic                 r_start_dp;
   logic                 r_round_en;
   logic                 r_blk_req;
   logic                 r_busy;
   logic                 r_status;
   logic                 r_intr;

   logic                 w_abort;
   logic                 w_last_round;
   logic                 w_last_blk;

`ifdef KECCAK_PERM_SEQ_ABORT_EN
   // Abort is meaningless in IDLE, so it is masked there.
   assign w_abort = bus.abort_i && (r_state != S_IDLE);
`else
   logic w_unused_abort;
   assign w_unused_abort = bus.abort_i;
   assign w_abort        = 1'b0;
`endif

   assign w_last_round = (r_round_idx == LAST_ROUND);
   assign w_last_blk   = (r_blk_idx == (r_blk_cnt - BLK_CNT_W'(1)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_blk_cnt   <= '0;
         r_blk_idx   <= '0;
         r_round_idx <= '0;
         r_start_dp  <= 1'b0;
         r_round_en  <= 1'b0;
         r_blk_req   <= 1'b0;
         r_busy      <= 1'b0;
         r_status    <= 1'b0;
         r_intr      <= 1'b0;
      end else begin
         // Launch and interrupt are single-cycle pulses.
         r_start_dp <= 1'b0;
         r_intr     <= 1'b0;
         if (w_abort) begin
            // Abort beats every other transition, including DONE entry.
            r_state     <= S_IDLE;
            r_blk_cnt   <= '0;
            r_blk_idx   <= '0;
            r_round_idx <= '0;
            r_round_en  <= 1'b0;
            r_blk_req   <= 1'b0;
            r_busy      <= 1'b0;
            r_status    <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start_i && bus.ready_dp_i) begin
                     if (bus.num_blocks_i != '0) begin
                        r_status    <= 1'b0;
                        r_blk_cnt   <= bus.num_blocks_i;
                        r_blk_idx   <= '0;
                        r_round_idx <= '0;
                        r_start_dp  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_LAUNCH;
                     end else begin
                        // Empty job completes at once; status is re-set on DONE entry.
                        r_status <= 1'b1;
                        r_intr   <= 1'b1;
                        r_state  <= S_DONE;
                     end
                  end
               end
               S_LAUNCH: begin
                  r_round_idx <= '0;
                  r_round_en  <= 1'b1;
                  r_state     <= S_ROUND;
               end
               S_ROUND: begin
                  if (w_last_round) begin
                     r_round_idx <= '0;
                     r_round_en  <= 1'b0;
                     if (w_last_blk) begin
                        r_busy   <= 1'b0;
                        r_status <= 1'b1;
                        r_intr   <= 1'b1;
                        r_state  <= S_DONE;
                     end else begin
                        r_blk_idx <= r_blk_idx + BLK_CNT_W'(1);
                        r_blk_req <= 1'b1;
                        r_state   <= S_BLK_WAIT;
                     end
                  end else begin
                     r_round_idx <= r_round_idx + ROUND_W'(1);
                  end
               end
               S_BLK_WAIT: begin
                  if (bus.blk_valid_i && bus.ready_dp_i) begin
                     r_blk_req  <= 1'b0;
                     r_start_dp <= 1'b1;
                     r_state    <= S_LAUNCH;
                  end
               end
               S_DONE: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.start_dp_o  = r_start_dp;
   assign bus.round_en_o  = r_round_en;
   assign bus.round_idx_o = r_round_idx;
   assign bus.blk_req_o   = r_blk_req;
   assign bus.blk_idx_o   = r_blk_idx;
   assign bus.busy_o      = r_busy;
   assign bus.status_o    = r_status;
   assign bus.keccak_intr = r_intr;
endmodule

// File: tb/tb_keccak_perm_seq.sv
`timescale 1ns/1ps
module tb_keccak_perm_seq;
   localparam int NR   = 24;
   localparam int NR12 = 12;
   localparam int BW   = 8;
`ifdef KECCAK_PERM_SEQ_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   keccak_perm_seq_if #(.NUM_ROUNDS(NR),   .BLK_CNT_W(BW)) bus   ();
   keccak_perm_seq_if #(.NUM_ROUNDS(NR12), .BLK_CNT_W(BW)) bus12 ();

   keccak_perm_seq #(.NUM_ROUNDS(NR),   .BLK_CNT_W(BW)) dut   (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
   keccak_perm_seq #(.NUM_ROUNDS(NR12), .BLK_CNT_W(BW)) dut12 (.clk_i(clk), .rst_ni(rst_n), .bus(bus12));

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Job-level model: m_t is the cycle position within the current block
   // (0 = launch, 1..NR = rounds, NR+1 = waiting for the next block).
   bit m_active, m_done, m_status;
   int m_t, m_blk, m_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0; m_done <= 1'b0; m_status <= 1'b0;
         m_t <= 0; m_blk <= 0; m_cnt <= 0;
      end else if (ABORT_EN && bus.abort_i && (m_active || m_done)) begin
         m_active <= 1'b0; m_done <= 1'b0; m_status <= 1'b0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (!m_active) begin
         if (bus.start_i && bus.ready_dp_i) begin
            if (bus.num_blocks_i == 0) begin
               m_done <= 1'b1; m_status <= 1'b1;
            end else begin
               m_status <= 1'b0; m_active <= 1'b1;
               m_cnt <= int'(bus.num_blocks_i); m_blk <= 0; m_t <= 0;
            end
         end
      end else if (m_t < NR) begin
         m_t <= m_t + 1;
      end else if (m_t == NR) begin
         if (m_blk == m_cnt - 1) begin
            m_active <= 1'b0; m_done <= 1'b1; m_status <= 1'b1;
         end else begin
            m_blk <= m_blk + 1; m_t <= NR + 1;
         end
      end else if (bus.blk_valid_i && bus.ready_dp_i) begin
         m_t <= 0;
      end
   end

   // Compare process and event counters, sampled on the falling edge.
   int n_sdp = 0, n_round = 0, n_intr = 0, last_sdp_cyc = 0;
   int n_sdp12 = 0, n_round12 = 0;
   initial forever begin
      @(negedge clk);
      check("start_dp", 32'(bus.start_dp_o), 32'(m_active && m_t == 0));
      check("round_en", 32'(bus.round_en_o), 32'(m_active && m_t >= 1 && m_t <= NR));
      check("blk_req",  32'(bus.blk_req_o),  32'(m_active && m_t == NR + 1));
      check("busy",     32'(bus.busy_o),     32'(m_active));
      check("intr",     32'(bus.keccak_intr), 32'(m_done));
      check("status",   32'(bus.status_o),   32'(m_status));
      if (m_active && m_t >= 1 && m_t <= NR)
         check("round_idx", 32'(bus.round_idx_o), 32'(m_t - 1));
      if (m_active)
         check("blk_idx", 32'(bus.blk_idx_o), 32'(m_blk));
      if (bus.start_dp_o) begin n_sdp++; last_sdp_cyc = cyc; end
      if (bus.round_en_o) n_round++;
      if (bus.keccak_intr) n_intr++;
      if (bus12.start_dp_o) n_sdp12++;
      if (bus12.round_en_o) n_round12++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic start_job(input int nb, output int k);
      bus.num_blocks_i = BW'(nb);
      bus.ready_dp_i   = 1'b1;
      bus.start_i      = 1'b1;
      @(posedge clk);
      #1 k = cyc;
      #1 bus.start_i = 1'b0;
   endtask

   task automatic wait_intr(input int limit, output bit ok, output int at);
      int n = 0;
      ok = 1'b0; at = 0;
      while (!ok && n < limit) begin
         @(negedge clk);
         n++;
         if (bus.keccak_intr) begin ok = 1'b1; at = cyc; end
      end
   endtask

   task automatic wait_round(input int idx, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (!ok && n < 60) begin
         @(negedge clk);
         n++;
         if (bus.round_en_o && int'(bus.round_idx_o) == idx) ok = 1'b1;
      end
   endtask

   task automatic wait_req(output bit ok);
      int n = 0;
      ok = 1'b0;
      while (!ok && n < 60) begin
         @(negedge clk);
         n++;
         if (bus.blk_req_o) ok = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int k, k2, at, s_sdp, s_round, s_intr;
      bit ok;
      bus.start_i = 0; bus.num_blocks_i = 0; bus.ready_dp_i = 0; bus.blk_valid_i = 0; bus.abort_i = 0;
      bus12.start_i = 0; bus12.num_blocks_i = 0; bus12.ready_dp_i = 0; bus12.blk_valid_i = 0; bus12.abort_i = 0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_busy",   32'(bus.busy_o), 0);
      check("rst_status", 32'(bus.status_o), 0);
      check("rst_intr",   32'(bus.keccak_intr), 0);
      check("rst_sdp",    32'(bus.start_dp_o), 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Single block: launch at +1, interrupt at +26.
      s_round = n_round;
      start_job(1, k);
      wait_intr(40, ok, at);
      check("job1_intr_seen", 32'(ok), 1);
      check("job1_intr_rel", 32'(at - k + 1), 26);
      tick(3);
      check("job1_sdp_rel", 32'(last_sdp_cyc - k + 1), 1);
      check("job1_rounds", 32'(n_round - s_round), 24);
      check("job1_status_sticky", 32'(bus.status_o), 1);

      // Three blocks, 5 extra cycles before each next block arrives.
      s_sdp = n_sdp; s_round = n_round; s_intr = n_intr;
      start_job(3, k);
      for (int g = 0; g < 2; g++) begin
         wait_req(ok);
         check("job2_req_seen", 32'(ok), 1);
         check("job2_req_idx", 32'(bus.blk_idx_o), 32'(g + 1));
         repeat (5) @(posedge clk);
         #2 bus.blk_valid_i = 1'b1;
         @(posedge clk);
         #2 bus.blk_valid_i = 1'b0;
      end
      wait_intr(80, ok, at);
      check("job2_intr_seen", 32'(ok), 1);
      check("job2_intr_rel", 32'(at - k + 1), 88);
      tick(2);
      check("job2_launches", 32'(n_sdp - s_sdp), 3);
      check("job2_rounds", 32'(n_round - s_round), 72);
      check("job2_intrs", 32'(n_intr - s_intr), 1);

      // start held high, datapath not ready at first.
      s_sdp = n_sdp; s_intr = n_intr;
      bus.num_blocks_i = 2; bus.ready_dp_i = 0; bus.blk_valid_i = 1; bus.start_i = 1;
      tick(3);
      check("job3_not_accepted", 32'(bus.busy_o), 0);
      check("job3_no_launch", 32'(n_sdp - s_sdp), 0);
      check("job3_status_kept", 32'(bus.status_o), 1);
      bus.ready_dp_i = 1;
      @(posedge clk);
      #1 k = cyc;
      @(negedge clk);
      check("job3_status_cleared", 32'(bus.status_o), 0);
      check("job3_launch", 32'(bus.start_dp_o), 1);
      wait_intr(80, ok, at);
      check("job3_intr_seen", 32'(ok), 1);
      check("job3_intr_rel", 32'(at - k + 1), 52);
      @(negedge clk);
      check("job3_idle_gap_busy", 32'(bus.busy_o), 0);
      check("job3_idle_gap_sdp", 32'(bus.start_dp_o), 0);
      @(posedge clk);
      #1 k2 = cyc;
      #1 bus.start_i = 0;
      @(negedge clk);
      check("job3b_launch", 32'(bus.start_dp_o), 1);
      wait_intr(80, ok, at);
      check("job3b_intr_rel", 32'(at - k2 + 1), 52);
      tick(2);
      bus.blk_valid_i = 0;
      check("job3_intrs", 32'(n_intr - s_intr), 2);

      // Reset in the middle of the rounds.
      start_job(1, k);
      wait_round(10, ok);
      check("rst_mid_round_seen", 32'(ok), 1);
      #1 rst_n = 1'b0;
      #1;
      check("rstm_sdp",   32'(bus.start_dp_o), 0);
      check("rstm_ren",   32'(bus.round_en_o), 0);
      check("rstm_ridx",  32'(bus.round_idx_o), 0);
      check("rstm_req",   32'(bus.blk_req_o), 0);
      check("rstm_bidx",  32'(bus.blk_idx_o), 0);
      check("rstm_busy",  32'(bus.busy_o), 0);
      check("rstm_stat",  32'(bus.status_o), 0);
      check("rstm_intr",  32'(bus.keccak_intr), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick(1);
      start_job(1, k);
      wait_intr(40, ok, at);
      check("post_rst_intr_rel", 32'(at - k + 1), 26);

      // Abort at round 5.
      tick(1);
      s_intr = n_intr;
      start_job(1, k);
      wait_round(5, ok);
      check("abort_round_seen", 32'(ok), 1);
      bus.abort_i = 1'b1;
      @(posedge clk);
      #2 bus.abort_i = 1'b0;
      if (ABORT_EN) begin
         @(negedge clk);
         check("abort_busy", 32'(bus.busy_o), 0);
         check("abort_status", 32'(bus.status_o), 0);
         tick(40);
         check("abort_no_intr", 32'(n_intr - s_intr), 0);
      end else begin
         wait_intr(40, ok, at);
         check("noabort_intr_rel", 32'(at - k + 1), 26);
         tick(2);
         check("noabort_status", 32'(bus.status_o), 1);
      end

      // NUM_ROUNDS=12 instance: empty job, then one block.
      s_sdp = n_sdp12; s_round = n_round12;
      bus12.num_blocks_i = 0; bus12.ready_dp_i = 1; bus12.start_i = 1;
      @(posedge clk);
      #1 k = cyc;
      #1 bus12.start_i = 0;
      @(negedge clk);
      check("r12_empty_intr", 32'(bus12.keccak_intr), 1);
      check("r12_empty_status", 32'(bus12.status_o), 1);
      tick(3);
      check("r12_empty_intr_gone", 32'(bus12.keccak_intr), 0);
      check("r12_empty_no_launch", 32'(n_sdp12 - s_sdp), 0);
      check("r12_empty_no_rounds", 32'(n_round12 - s_round), 0);
      check("r12_status_sticky", 32'(bus12.status_o), 1);
      bus12.num_blocks_i = 1; bus12.start_i = 1;
      @(posedge clk);
      #1 k = cyc;
      #1 bus12.start_i = 0;
      begin
         int n = 0;
         ok = 1'b0;
         while (!ok && n < 30) begin
            @(negedge clk);
            n++;
            if (bus12.keccak_intr) begin ok = 1'b1; at = cyc; end
         end
      end
      check("r12_intr_seen", 32'(ok), 1);
      check("r12_intr_rel", 32'(at - k + 1), 14);
      tick(2);
      check("r12_rounds", 32'(n_round12 - s_round), 12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
